// File: rtl/alt_trigout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alt_trigout_pkg
//  Description : Shared types and widths for the alt_trigout timestamp
//                capture path (queue entry layout, FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package alt_trigout_pkg;

    localparam int NSRC  = 5;   // 4 channels + external trigger
    localparam int SEC_W = 40;  // WR seconds width
    localparam int CYC_W = 28;  // WR cycles width

    // One queued timestamp event: 40 + 28 + 4 + 1 = 73 bits.
    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [CYC_W-1:0] cycles;
        logic [3:0]       ch_mask;
        logic             ext_mask;
    } ts_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUSH    = 2'd2
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/alt_trigout_sfifo.sv
`default_nettype none
// ============================================================================
//  Module      : alt_trigout_sfifo
//  Description : Single-clock show-ahead FIFO of ts_entry_t. The head entry
//                is visible on dout_o whenever empty_o is low; dout_o is 0
//                while empty. A pop on an empty FIFO is ignored. Push and pop
//                in the same cycle both succeed, including when full.
//  Ports       : clk_i, rst_n_i (async active-low), push_i, pop_i, din_i,
//                full_o, empty_o, dout_o
//  Revision    : 1.0 - initial release
// ============================================================================
module alt_trigout_sfifo
    import alt_trigout_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  ts_entry_t din_i,
    output logic      full_o,
    output logic      empty_o,
    output ts_entry_t dout_o
);

    localparam int AW = $clog2(DEPTH);

    ts_entry_t        r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A simultaneous pop frees the slot a push into a full FIFO needs.
    assign w_pop  = pop_i & ~w_empty;
    assign w_push = push_i & (~w_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din_i;
    end

    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign dout_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/alt_trigout_ts_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alt_trigout_ts_ctrl
//  Description : Trigger timestamp capture and queue controller. Rising
//                edges on enabled sources are stamped with WR time, merged
//                over a COALESCE-cycle window and queued in a show-ahead FIFO
//                popped by the register bank's ts_cycles read strobe.
//  Ports       : clk_i, rst_n_i (async active-low)
//                ch_trig_i[4], ext_trig_i, ch_enable_i[4], ext_enable_i
//                wr_valid_i, tm_sec_i[40], tm_cycles_i[28]
//                pop_i, clr_ovf_i
//                ts_present_o, ts_sec_o[40], ts_cycles_o[28], ch_mask_o[4],
//                ext_mask_o, overflow_o, evcnt_o[32]
//  Options     : ALT_TRIGOUT_EVCNT_EN - when defined, evcnt_o counts entries
//                written into the FIFO; otherwise evcnt_o is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module alt_trigout_ts_ctrl
    import alt_trigout_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int COALESCE = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [3:0]        ch_trig_i,
    input  logic              ext_trig_i,
    input  logic [3:0]        ch_enable_i,
    input  logic              ext_enable_i,
    input  logic              wr_valid_i,
    input  logic [SEC_W-1:0]  tm_sec_i,
    input  logic [CYC_W-1:0]  tm_cycles_i,
    input  logic              pop_i,
    input  logic              clr_ovf_i,
    output logic              ts_present_o,
    output logic [SEC_W-1:0]  ts_sec_o,
    output logic [CYC_W-1:0]  ts_cycles_o,
    output logic [3:0]        ch_mask_o,
    output logic              ext_mask_o,
    output logic              overflow_o,
    output logic [31:0]       evcnt_o
);

    localparam logic [3:0] C_COALESCE_CNT = 4'(COALESCE);

    fsm_state_t        r_state;
    fsm_state_t        w_state_nxt;
    logic [NSRC-1:0]   r_src_d;
    logic [NSRC-1:0]   w_src;
    logic [NSRC-1:0]   w_hit;
    logic [NSRC-1:0]   r_mask;
    logic [NSRC-1:0]   w_mask_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [SEC_W-1:0]  r_sec;
    logic [CYC_W-1:0]  r_cyc;
    logic              w_latch;
    logic              w_push_req;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;
    logic              r_ovf;
    ts_entry_t         w_din;
    ts_entry_t         w_head;

    // Edge detect: bit 4 is the external trigger.
    assign w_src = {ext_trig_i, ch_trig_i};
    assign w_hit = w_src & ~r_src_d & {ext_enable_i, ch_enable_i};

    // ------------------------------------------------------------------
    // FSM state and entry-assembly registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_src_d <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_sec   <= '0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src_d <= w_src;
            r_mask  <= w_mask_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_sec <= tm_sec_i;
                r_cyc <= tm_cycles_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_latch     = 1'b0;
        w_push_req  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Edges without valid WR time cannot be stamped; drop them.
                if ((|w_hit) && wr_valid_i) begin
                    w_latch    = 1'b1;
                    w_mask_nxt = w_hit;
                    if (COALESCE == 0) begin
                        w_state_nxt = ST_PUSH;
                    end else begin
                        w_state_nxt = ST_COLLECT;
                        w_cnt_nxt   = C_COALESCE_CNT;
                    end
                end
            end
            ST_COLLECT: begin
                // Timestamp stays at the first edge; later edges only widen
                // the mask.
                w_mask_nxt = r_mask | w_hit;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_PUSH;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_PUSH: begin
                w_push_req  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    assign w_din = '{sec:      r_sec,
                     cycles:   r_cyc,
                     ch_mask:  r_mask[3:0],
                     ext_mask: r_mask[4]};

    alt_trigout_sfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (w_push_req),
        .pop_i   (pop_i),
        .din_i   (w_din),
        .full_o  (w_full),
        .empty_o (w_empty),
        .dout_o  (w_head)
    );

    // A pop in the push cycle makes room, so only an unrelieved full drops.
    assign w_ovf_set = w_push_req & w_full & ~pop_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef ALT_TRIGOUT_EVCNT_EN
    logic        w_push_ok;
    logic [31:0] r_evcnt;

    assign w_push_ok = w_push_req & (~w_full | (pop_i & ~w_empty));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_evcnt <= '0;
        end else if (w_push_ok) begin
            r_evcnt <= r_evcnt + 32'd1;
        end
    end

    assign evcnt_o = r_evcnt;
`else
    assign evcnt_o = '0;
`endif

    assign ts_present_o = ~w_empty;
    assign ts_sec_o     = w_head.sec;
    assign ts_cycles_o  = w_head.cycles;
    assign ch_mask_o    = w_head.ch_mask;
    assign ext_mask_o   = w_head.ext_mask;
    assign overflow_o   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alt_trigout_ts_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alt_trigout_ts_ctrl
//  Description : Directed vector bench for alt_trigout_ts_ctrl
//                (DEPTH = 4, COALESCE = 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alt_trigout_ts_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ch_trig;
    logic        ext_trig;
    logic [3:0]  ch_en;
    logic        ext_en;
    logic        wr_valid;
    logic [39:0] tm_sec;
    logic [27:0] tm_cyc;
    logic        pop;
    logic        clr_ovf;
    logic        present;
    logic [39:0] h_sec;
    logic [27:0] h_cyc;
    logic [3:0]  h_mask;
    logic        h_ext;
    logic        ovf;
    logic [31:0] evcnt;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_evcnt = 0;

    alt_trigout_ts_ctrl #(
        .DEPTH    (4),
        .COALESCE (3)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .ch_trig_i    (ch_trig),
        .ext_trig_i   (ext_trig),
        .ch_enable_i  (ch_en),
        .ext_enable_i (ext_en),
        .wr_valid_i   (wr_valid),
        .tm_sec_i     (tm_sec),
        .tm_cycles_i  (tm_cyc),
        .pop_i        (pop),
        .clr_ovf_i    (clr_ovf),
        .ts_present_o (present),
        .ts_sec_o     (h_sec),
        .ts_cycles_o  (h_cyc),
        .ch_mask_o    (h_mask),
        .ext_mask_o   (h_ext),
        .overflow_o   (ovf),
        .evcnt_o      (evcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ch;
        logic        ext;
        logic [3:0]  ch_en;
        logic        ext_en;
        logic        wrv;
        logic [39:0] sec;
        logic [27:0] cyc;
        logic        exp_p;
        logic [3:0]  exp_m;
        logic        exp_x;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry counter expectation tracks only when the counter is built in.
    task automatic note_accept();
`ifdef ALT_TRIGOUT_EVCNT_EN
        exp_evcnt++;
`endif
    endtask

    // One-cycle trigger pulse stamped with (sec, cyc); time moves on after.
    task automatic fire(input logic [3:0] ch, input logic ext,
                        input logic [39:0] sec, input logic [27:0] cyc);
        tm_sec   = sec;
        tm_cyc   = cyc;
        ch_trig  = ch;
        ext_trig = ext;
        tick();
        ch_trig  = 4'b0;
        ext_trig = 1'b0;
        tm_sec   = ~sec;
        tm_cyc   = cyc + 28'd500;
    endtask

    // Pulse plus enough cycles for the entry to land and the FSM to idle.
    task automatic event_wait(input logic [39:0] sec);
        fire(4'b0001, 1'b0, sec, 28'(sec) + 28'd7);
        repeat (6) tick();
    endtask

    task automatic pop_one();
        @(negedge clk);
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ch_trig = '0; ext_trig = 1'b0; ch_en = '0; ext_en = 1'b0;
        wr_valid = 1'b1; tm_sec = '0; tm_cyc = '0; pop = 1'b0; clr_ovf = 1'b0;

        //            ch     ext  ch_en  ext_en wrv  sec             cyc    p  mask   x
        vt[0] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 1'b1, 40'h12_3456_789A, 28'd1000, 1'b1, 4'b0010, 1'b0};
        vt[1] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 40'h1,           28'd1,    1'b0, 4'b0000, 1'b0};
        vt[2] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 40'h2,           28'd2,    1'b0, 4'b0000, 1'b0};
        vt[3] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 40'hFF_0000_0001, 28'hFFF_FFFF, 1'b1, 4'b1000, 1'b1};
        vt[4] = '{4'b1111, 1'b1, 4'b0101, 1'b0, 1'b1, 40'h0,           28'd0,    1'b1, 4'b0101, 1'b0};
        vt[5] = '{4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1, 40'h3,           28'd3,    1'b0, 4'b0000, 1'b0};

        // Reset state
        #3;
        chk("rst_present", 64'(present), 64'd0);
        chk("rst_ovf",     64'(ovf),     64'd0);
        chk("rst_head",    {h_sec, h_mask, h_ext}, 64'd0);
        chk("rst_evcnt",   64'(evcnt),   64'd0);
        #9 rst_n = 1'b1;
        tick();

        // Table: single events, enables, wr_valid gating, timing of present
        for (int i = 0; i < 6; i++) begin
            ch_en    = vt[i].ch_en;
            ext_en   = vt[i].ext_en;
            wr_valid = vt[i].wrv;
            fire(vt[i].ch, vt[i].ext, vt[i].sec, vt[i].cyc);
            wr_valid = 1'b1;
            repeat (4) tick();
            @(negedge clk);
            chk($sformatf("v%0d_early", i), 64'(present), 64'd0);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_present", i), 64'(present), 64'(vt[i].exp_p));
            if (vt[i].exp_p) begin
                note_accept();
                chk($sformatf("v%0d_sec", i),  64'(h_sec),  64'(vt[i].sec));
                chk($sformatf("v%0d_cyc", i),  64'(h_cyc),  64'(vt[i].cyc));
                chk($sformatf("v%0d_mask", i), {h_mask, h_ext}, {vt[i].exp_m, vt[i].exp_x});
                pop_one();
                @(negedge clk);
                chk($sformatf("v%0d_popped", i), 64'(present), 64'd0);
            end
            chk($sformatf("v%0d_evcnt", i), 64'(evcnt), 64'(exp_evcnt));
            tick();
        end

        // Coalescing: ch1 at t, ext at t+2, ch1 again at t+3 -> one entry
        ch_en = 4'b0001; ext_en = 1'b1;
        fire(4'b0001, 1'b0, 40'd5, 28'd77);
        tick();
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        ch_trig = 4'b0001; tick(); ch_trig = 4'b0000;
        repeat (3) tick();
        @(negedge clk);
        note_accept();
        chk("co_present", 64'(present), 64'd1);
        chk("co_stamp",   {h_sec[35:0], h_cyc}, {36'd5, 28'd77});
        chk("co_mask",    {h_mask, h_ext}, {4'b0001, 1'b1});
        pop_one();
        repeat (6) tick();
        chk("co_single",  64'(present), 64'd0);

        // Overflow: 5 events into a 4-deep queue, sec = 0..4; sec 4 dropped
        for (int k = 0; k < 5; k++) event_wait(40'(k));
        @(negedge clk);
        repeat (4) note_accept();
        chk("of_set",  64'(ovf), 64'd1);
        chk("of_head", 64'(h_sec), 64'd0);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        @(negedge clk);
        chk("of_clr", 64'(ovf), 64'd0);

        // Event sec=6 whose push coincides with a pop while full
        tick();
        fire(4'b0001, 1'b0, 40'd6, 28'd13);
        repeat (4) tick();
        pop = 1'b1; tick(); pop = 1'b0;
        note_accept();
        repeat (2) tick();
        @(negedge clk);
        chk("pp_ovf",  64'(ovf),   64'd0);
        chk("pp_head", 64'(h_sec), 64'd1);
        chk("pp_evcnt", 64'(evcnt), 64'(exp_evcnt));

        // Drain: 1, 2, 3, 6 then empty
        begin
            logic [39:0] order [4];
            order = '{40'd1, 40'd2, 40'd3, 40'd6};
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("dr%0d_present", k), 64'(present), 64'd1);
                chk($sformatf("dr%0d_sec", k),     64'(h_sec),   64'(order[k]));
                pop_one();
            end
        end
        @(negedge clk);
        chk("dr_empty", 64'(present), 64'd0);
        pop_one();
        @(negedge clk);
        chk("pe_present", 64'(present), 64'd0);
        chk("pe_head",    {h_sec, h_mask, h_ext}, 64'd0);

        // Refill across pointer wrap, then drain in order
        for (int k = 0; k < 4; k++) begin
            event_wait(40'(10 + k));
            note_accept();
        end
        @(negedge clk);
        chk("wr_ovf", 64'(ovf), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wr%0d_sec", k), 64'(h_sec), 64'(10 + k));
            chk($sformatf("wr%0d_cyc", k), 64'(h_cyc), 64'(17 + k));
            pop_one();
        end
        @(negedge clk);
        chk("wr_empty", 64'(present), 64'd0);
        chk("wr_evcnt", 64'(evcnt), 64'(exp_evcnt));

        // Asynchronous reset in the middle of COLLECT with an entry queued
        event_wait(40'd20);
        fire(4'b0001, 1'b0, 40'd21, 28'd9);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_present", 64'(present), 64'd0);
        chk("ar_head",    {h_sec, h_mask, h_ext}, 64'd0);
        chk("ar_evcnt",   64'(evcnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_evcnt = 0;
        repeat (8) tick();
        @(negedge clk);
        chk("ar_noentry", 64'(present), 64'd0);
        chk("ar_evcnt0",  64'(evcnt),   64'd0);
        event_wait(40'd30);
        note_accept();
        @(negedge clk);
        chk("ar_after",   64'(h_sec),   64'd30);
        chk("ar_evcnt1",  64'(evcnt),   64'(exp_evcnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
